// File: rtl/bs_unzlib.sv
// rtl/bs_unzlib.sv - zlib header and fixed-Huffman block parser emitting LZ77 tokens
module bs_unzlib #(
    parameter int DATA_WD    = 32,
    parameter int LIT_DAT_WD = 8,
    parameter int LEN_DAT_WD = 7,
    parameter int DIS_DAT_WD = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  val_i,
    input  logic [DATA_WD-1:0]    dat_i,
    output logic                  rdy_o,
    output logic                  val_o,
    output logic                  flg_lit_o,
    output logic [LIT_DAT_WD-1:0] lit_dat_o,
    output logic [LEN_DAT_WD-1:0] len_dat_o,
    output logic [DIS_DAT_WD-1:0] dis_dat_o,
    output logic                  lst_o,
    output logic [31:0]           adler_o,
    output logic                  done_o,
    output logic                  err_o
);
    localparam int BUF_WD = 2 * DATA_WD;
    localparam int CNT_WD = $clog2(BUF_WD + 1);
    localparam int T      = BUF_WD - 1;

    localparam logic [3:0] S_IDLE  = 4'd0, S_HDR  = 4'd1, S_BLK = 4'd2, S_SYM  = 4'd3,
                           S_DIST  = 4'd4, S_ALIGN = 4'd5, S_ADLER = 4'd6, S_PAD = 4'd7,
                           S_DONE  = 4'd8, S_ERR  = 4'd9;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
    endfunction

    // Extra bits arrive LSB-first: the first consumed bit is bit 0 of the value.
    function automatic logic [4:0] ext_val(input logic [4:0] raw, input logic [2:0] n);
        ext_val = '0;
        for (int i = 0; i < 5; i++)
            if (i < int'(n)) ext_val[i] = raw[4-i];
    endfunction

    logic [3:0]            state_q, state_d;
    logic [BUF_WD-1:0]     buf_q, buf_d;
    logic [CNT_WD-1:0]     cnt_q, cnt_d, ncon, cnt_mid;
    logic                  hv_q, hv_d, hflg_q, hflg_d;
    logic [LIT_DAT_WD-1:0] hlit_q, hlit_d;
    logic [LEN_DAT_WD-1:0] hlen_q, hlen_d, mlen_q, mlen_d;
    logic [DIS_DAT_WD-1:0] hdis_q, hdis_d;
    logic                  emit, emit_lst, clr, err_d, done_d, acc;
    logic                  nt, nt_flg;
    logic [LIT_DAT_WD-1:0] nt_lit;
    logic [31:0]           adler_d;
    logic [8:0]            p9;
    logic [6:0]            c7, lval, dval;
    logic [7:0]            c8, cmf, flg;
    logic [4:0]            li, dc;
    logic [2:0]            leb, deb;

    assign rdy_o = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR)
                   && (cnt_q <= CNT_WD'(DATA_WD));
    assign acc   = val_i && rdy_o;

    always_comb begin
        p9   = buf_q[T -: 9];
        c7   = p9[8:2];
        c8   = p9[8:1];
        li   = 5'(c7 - 7'd1);
        leb  = (li < 5'd8) ? 3'd0 : li[4:2] - 3'd1;
        lval = (li < 5'd8) ? 7'(li) + 7'd3
             : ((7'd4 + 7'(li[1:0])) << leb) + 7'd3 + 7'(ext_val(buf_q[T-7 -: 5], leb));
        dc   = buf_q[T -: 5];
        deb  = (dc < 5'd4) ? 3'd0 : dc[3:1] - 3'd1;
        dval = (dc < 5'd4) ? 7'(dc) + 7'd1
             : ((7'd2 + 7'(dc[0])) << deb) + 7'd1 + 7'(ext_val(buf_q[T-5 -: 5], deb));
        cmf  = rev8(buf_q[T -: 8]);
        flg  = rev8(buf_q[T-8 -: 8]);
    end

    always_comb begin
        state_d  = state_q;
        ncon     = '0;
        hv_d     = hv_q;
        hflg_d   = hflg_q;
        hlit_d   = hlit_q;
        hlen_d   = hlen_q;
        hdis_d   = hdis_q;
        mlen_d   = mlen_q;
        emit     = 1'b0;
        emit_lst = 1'b0;
        clr      = 1'b0;
        err_d    = err_o;
        done_d   = 1'b0;
        adler_d  = adler_o;
        nt       = 1'b0;
        nt_flg   = 1'b0;
        nt_lit   = '0;
        case (state_q)
            S_IDLE, S_ERR: if (start_i) begin
                clr     = 1'b1;
                err_d   = 1'b0;
                hv_d    = 1'b0;
                state_d = S_HDR;
            end
            S_HDR: if (cnt_q >= CNT_WD'(16)) begin
                ncon = CNT_WD'(16);
                if (cmf == 8'h78 && !flg[5] && ({cmf, flg} % 16'd31) == 16'd0) state_d = S_BLK;
                else begin state_d = S_ERR; err_d = 1'b1; end
            end
            S_BLK: if (cnt_q >= CNT_WD'(3)) begin
                ncon = CNT_WD'(3);
                if (buf_q[T] && {buf_q[T-2], buf_q[T-1]} == 2'b01) state_d = S_SYM;
                else begin state_d = S_ERR; err_d = 1'b1; end
            end
            S_SYM: if (cnt_q >= CNT_WD'(12)) begin
                if (c7 == 7'd0) begin
                    ncon = CNT_WD'(7);
                    if (hv_q) begin
                        emit = 1'b1; emit_lst = 1'b1; hv_d = 1'b0; state_d = S_ALIGN;
                    end else begin
                        state_d = S_ERR; err_d = 1'b1;
                    end
                end else if (c7 <= 7'd20) begin
                    ncon    = CNT_WD'(7) + CNT_WD'(leb);
                    mlen_d  = LEN_DAT_WD'(lval);
                    state_d = S_DIST;
                end else if (c7 <= 7'd23 || (c8 >= 8'hC0 && c8 <= 8'hC7)) begin
                    state_d = S_ERR; err_d = 1'b1;
                end else if (c8 <= 8'hBF) begin
                    ncon = CNT_WD'(8); nt = 1'b1; nt_flg = 1'b1;
                    nt_lit = LIT_DAT_WD'(c8 - 8'h30);
                end else begin
                    ncon = CNT_WD'(9); nt = 1'b1; nt_flg = 1'b1;
                    nt_lit = LIT_DAT_WD'(p9[7:0]);
                end
            end
            S_DIST: if (cnt_q >= CNT_WD'(9)) begin
                if (dc >= 5'd12) begin
                    state_d = S_ERR; err_d = 1'b1;
                end else begin
                    ncon = CNT_WD'(5) + CNT_WD'(deb); nt = 1'b1; state_d = S_SYM;
                end
            end
            S_ALIGN: begin
                ncon    = CNT_WD'(cnt_q[2:0]);
                state_d = S_ADLER;
            end
            S_ADLER: if (cnt_q >= CNT_WD'(32)) begin
                ncon    = CNT_WD'(32);
                adler_d = {rev8(buf_q[T -: 8]), rev8(buf_q[T-8 -: 8]),
                           rev8(buf_q[T-16 -: 8]), rev8(buf_q[T-24 -: 8])};
                state_d = S_PAD;
            end
            S_PAD: begin
                ncon = cnt_q; done_d = 1'b1; state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // One-deep hold: a new token pushes the previous one out.
        if (nt) begin
            emit   = hv_q;
            hv_d   = 1'b1;
            hflg_d = nt_flg;
            hlit_d = nt_flg ? nt_lit : '0;
            hlen_d = nt_flg ? '0 : mlen_q;
            hdis_d = nt_flg ? '0 : DIS_DAT_WD'(dval);
        end
        cnt_mid = cnt_q - ncon;
        buf_d   = buf_q << ncon;
        cnt_d   = cnt_mid;
        if (acc) begin
            buf_d = buf_d | ({dat_i, {DATA_WD{1'b0}}} >> cnt_mid);
            cnt_d = cnt_mid + CNT_WD'(DATA_WD);
        end
        if (clr) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            hv_q      <= 1'b0;
            hflg_q    <= 1'b0;
            hlit_q    <= '0;
            hlen_q    <= '0;
            hdis_q    <= '0;
            mlen_q    <= '0;
            val_o     <= 1'b0;
            flg_lit_o <= 1'b0;
            lit_dat_o <= '0;
            len_dat_o <= '0;
            dis_dat_o <= '0;
            lst_o     <= 1'b0;
            adler_o   <= '0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            hv_q    <= hv_d;
            hflg_q  <= hflg_d;
            hlit_q  <= hlit_d;
            hlen_q  <= hlen_d;
            hdis_q  <= hdis_d;
            mlen_q  <= mlen_d;
            val_o   <= emit;
            lst_o   <= emit && emit_lst;
            if (emit) begin
                flg_lit_o <= hflg_q;
                lit_dat_o <= hlit_q;
                len_dat_o <= hlen_q;
                dis_dat_o <= hdis_q;
            end
            adler_o <= adler_d;
            done_o  <= done_d;
            err_o   <= err_d;
        end
    end
endmodule
